// File: rtl/ecrc_sequencer_if.sv
// ---------------------------------------------------------------------------
// ecrc_sequencer_if
//
// Purpose: bundles every bus signal of the ECRC sequencer into one interface.
// There are three groups of signals:
//   - TLP beat input (ECRC_i_*, ECRC_o_Ready) from the fragmentation buffer.
//   - Drive to and return from the combinational CRC32 engine (CRC_*).
//   - Final ECRC output (ECRC_o_*, ECRC_i_Ready) toward the framer.
//
// Modports:
//   slave  - the sequencer side.
//   master - the environment side: buffer, engine and framer.
//
// Handshake semantics for both valid/ready pairs:
//   - A transfer happens on a rising clk edge where valid and ready are both 1.
//   - Once raised, valid and its payload stay stable until that transfer.
//   - Ready may change freely.
// ---------------------------------------------------------------------------
interface ecrc_sequencer_if #(
    parameter int DATA_WIDTH   = 256,
    parameter int LENGTH_WIDTH = 4,
    parameter int POLY_WIDTH   = 32,
    parameter int CNT_WIDTH    = 11
);
    logic                    ECRC_i_Valid;
    logic                    ECRC_i_SOP;
    logic                    ECRC_i_EOP;
    logic [DATA_WIDTH-1:0]   ECRC_i_Data;
    logic [LENGTH_WIDTH-1:0] ECRC_i_Length;
    logic                    ECRC_o_Ready;
    logic [DATA_WIDTH-1:0]   CRC_o_Message;
    logic [LENGTH_WIDTH-1:0] CRC_o_Length;
    logic                    CRC_o_EN;
    logic [POLY_WIDTH-1:0]   CRC_o_Seed;
    logic                    CRC_o_Seed_Load;
    logic [POLY_WIDTH-1:0]   CRC_i_CRC;
    logic                    ECRC_o_Valid;
    logic [POLY_WIDTH-1:0]   ECRC_o_ECRC;
    logic                    ECRC_i_Ready;
    logic [CNT_WIDTH-1:0]    ECRC_o_DW_Count;
    logic                    ECRC_o_Err;

    modport slave (
        input  ECRC_i_Valid, ECRC_i_SOP, ECRC_i_EOP, ECRC_i_Data, ECRC_i_Length,
        input  CRC_i_CRC, ECRC_i_Ready,
        output ECRC_o_Ready, CRC_o_Message, CRC_o_Length, CRC_o_EN, CRC_o_Seed,
        output CRC_o_Seed_Load, ECRC_o_Valid, ECRC_o_ECRC, ECRC_o_DW_Count, ECRC_o_Err
    );

    modport master (
        output ECRC_i_Valid, ECRC_i_SOP, ECRC_i_EOP, ECRC_i_Data, ECRC_i_Length,
        output CRC_i_CRC, ECRC_i_Ready,
        input  ECRC_o_Ready, CRC_o_Message, CRC_o_Length, CRC_o_EN, CRC_o_Seed,
        input  CRC_o_Seed_Load, ECRC_o_Valid, ECRC_o_ECRC, ECRC_o_DW_Count, ECRC_o_Err
    );
endinterface

// File: rtl/ecrc_sequencer.sv
// ---------------------------------------------------------------------------
// ecrc_sequencer
//
// Purpose: multi-beat controller around a combinational CRC32 engine that
// produces a TLP's ECRC.
//   - Seeds the engine with all-ones on SOP.
//   - Chains the running CRC across the following beats.
//   - Registers the inverted final CRC on the EOP beat.
//   - Holds that result on a valid/ready output until the framer takes it.
//
// Ports:
//   clk          sole clock, rising edge.
//   rst          asynchronous, active-high reset.
//   bus          ecrc_sequencer_if.slave; it carries three groups:
//                  - the beat input (Valid/SOP/EOP/Data/Length, o_Ready);
//                  - the engine drive (Message/Length/EN/Seed/Seed_Load)
//                    and its same-cycle CRC return;
//                  - the ECRC output (Valid/ECRC/DW_Count), its i_Ready,
//                    and the sticky Err flag.
//   o_dbg_state  current FSM state, for debug and checkers.
//
// Optional feature: define ECRC_VARIANT_MASK_EN to force the PCIe variant bits
// of the SOP beat to 1 before the beat reaches the engine. The forced bits are
// DW0 bit 24 (Type[0]) and DW0 bit 14 (EP).
//
// Handshake semantics:
//   - A beat is accepted when ECRC_i_Valid && ECRC_o_Ready.
//   - The ECRC is taken when ECRC_o_Valid && ECRC_i_Ready.
//   - ECRC_o_Ready is low while an ECRC is pending, so TLPs never overlap.
// ---------------------------------------------------------------------------
module ecrc_sequencer #(
    parameter int DATA_WIDTH   = 256,
    parameter int LENGTH_WIDTH = 4,
    parameter int POLY_WIDTH   = 32,
    parameter int CNT_WIDTH    = 11
) (
    input  logic               clk,
    input  logic               rst,
    ecrc_sequencer_if.slave    bus,
    output logic [1:0]         o_dbg_state
);
    localparam int MAX_DW = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [POLY_WIDTH-1:0]   r_run_crc;
    logic [POLY_WIDTH-1:0]   r_ecrc;
    logic                    r_valid;
    logic [CNT_WIDTH-1:0]    r_count;
    logic                    r_err;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_stray;
    logic                    w_engine_en;
    logic                    w_len_bad;
    logic [CNT_WIDTH:0]      w_sum;
    logic [CNT_WIDTH-1:0]    w_count_add;
    logic [CNT_WIDTH-1:0]    w_count_sop;
    logic [DATA_WIDTH-1:0]   w_msg;

    assign w_ready  = (r_state != S_OUT);
    assign w_accept = bus.ECRC_i_Valid && w_ready;

    // A beat in IDLE without SOP belongs to no TLP. It is consumed so the
    // buffer does not stall, but it never touches the engine or the count.
    assign w_stray     = (r_state == S_IDLE) && !bus.ECRC_i_SOP;
    assign w_engine_en = w_accept && !w_stray;

    assign w_len_bad = (bus.ECRC_i_Length == '0) || (int'(bus.ECRC_i_Length) > MAX_DW);

    // Saturating DW count; the sum keeps one extra bit to detect overflow.
    assign w_sum       = {1'b0, r_count} + {{(CNT_WIDTH + 1 - LENGTH_WIDTH){1'b0}}, bus.ECRC_i_Length};
    assign w_count_add = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
    assign w_count_sop = {{(CNT_WIDTH - LENGTH_WIDTH){1'b0}}, bus.ECRC_i_Length};

    always_comb begin
        w_msg = bus.ECRC_i_Data;
`ifdef ECRC_VARIANT_MASK_EN
        // The variant bits are excluded from ECRC coverage by treating them as 1.
        if (bus.ECRC_i_SOP) begin
            w_msg[DATA_WIDTH-8]  = 1'b1;
            w_msg[DATA_WIDTH-18] = 1'b1;
        end
`endif
    end

    assign bus.ECRC_o_Ready    = w_ready;
    assign bus.CRC_o_Message   = w_msg;
    assign bus.CRC_o_Length    = bus.ECRC_i_Length;
    assign bus.CRC_o_EN        = w_engine_en;
    assign bus.CRC_o_Seed_Load = w_accept && bus.ECRC_i_SOP;
    assign bus.CRC_o_Seed      = bus.ECRC_i_SOP ? {POLY_WIDTH{1'b1}} : r_run_crc;
    assign bus.ECRC_o_Valid    = r_valid;
    assign bus.ECRC_o_ECRC     = r_ecrc;
    assign bus.ECRC_o_DW_Count = r_count;
    assign bus.ECRC_o_Err      = r_err;
    assign o_dbg_state         = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && bus.ECRC_i_SOP)
                    w_next_state = bus.ECRC_i_EOP ? S_OUT : S_ACCUM;
            end
            S_ACCUM: begin
                // A restarting SOP beat also lands here; only EOP ends the TLP.
                if (w_accept && bus.ECRC_i_EOP)
                    w_next_state = S_OUT;
            end
            S_OUT: begin
                if (bus.ECRC_i_Ready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_run_crc <= {POLY_WIDTH{1'b1}};
            r_ecrc    <= '0;
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_engine_en) begin
                r_run_crc <= bus.CRC_i_CRC;
                r_count   <= bus.ECRC_i_SOP ? w_count_sop : w_count_add;
            end

            if (w_engine_en && bus.ECRC_i_EOP) begin
                r_ecrc  <= ~bus.CRC_i_CRC;
                r_valid <= 1'b1;
            end else if (r_state == S_OUT && bus.ECRC_i_Ready) begin
                r_valid <= 1'b0;
            end

            if (w_accept && (w_stray || w_len_bad || (r_state == S_ACCUM && bus.ECRC_i_SOP)))
                r_err <= 1'b1;
        end
    end
endmodule
